// File: rtl/secuencia_merged.sv
// rtl/secuencia_merged.sv - Moore equal-run detector with value-merged states; SECUENCIA_STATE_OUT_EN exposes run_val/run_cnt
module secuencia_merged #(
    parameter int RUN_LEN = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z
`ifdef SECUENCIA_STATE_OUT_EN
    ,
    output logic                           run_val,
    output logic [$clog2(RUN_LEN+1)-1:0]   run_cnt
`endif
);

    localparam int CW = $clog2(RUN_LEN + 1);

    generate
        if (RUN_LEN < 2 || RUN_LEN > 15) begin : g_bad_run_len
            $error("secuencia_merged: RUN_LEN must be in 2..15");
        end
    endgenerate

    typedef enum logic {
        ST_A   = 1'b0,
        ST_RUN = 1'b1
    } phase_t;

    phase_t        phase = ST_A;
    logic          val   = 1'b0;
    logic [CW-1:0] cnt   = '0;
    logic          z_q   = 1'b0;

    logic [CW-1:0] cnt_next;
    logic          val_next;

    // A change of value restarts the run at length 1 rather than returning to A.
    always_comb begin
        cnt_next = CW'(1);
        val_next = w;
        if (phase == ST_RUN && w == val) begin
            val_next = val;
            if (cnt == CW'(RUN_LEN))
                cnt_next = cnt;
            else
                cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= ST_A;
            val   <= 1'b0;
            cnt   <= '0;
            z_q   <= 1'b0;
        end else begin
            phase <= ST_RUN;
            val   <= val_next;
            cnt   <= cnt_next;
            z_q   <= (cnt_next == CW'(RUN_LEN));
        end
    end

    assign z = z_q;

`ifdef SECUENCIA_STATE_OUT_EN
    assign run_val = val;
    assign run_cnt = cnt;
`endif

endmodule

// File: tb/tb_secuencia_merged.sv
// tb/tb_secuencia_merged.sv - scoreboard bench for secuencia_merged at RUN_LEN=2 and RUN_LEN=3
module tb_secuencia_merged;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset2 = 1'b0, w2 = 1'b0, z2;
    logic reset3 = 1'b0, w3 = 1'b0, z3;
`ifdef SECUENCIA_STATE_OUT_EN
    logic       rv2, rv3;
    logic [1:0] rc2, rc3;
`endif

    secuencia_merged #(.RUN_LEN(2)) dut2 (
        .clk(clk), .reset(reset2), .w(w2), .z(z2)
`ifdef SECUENCIA_STATE_OUT_EN
        , .run_val(rv2), .run_cnt(rc2)
`endif
    );

    secuencia_merged #(.RUN_LEN(3)) dut3 (
        .clk(clk), .reset(reset3), .w(w3), .z(z3)
`ifdef SECUENCIA_STATE_OUT_EN
        , .run_val(rv3), .run_cnt(rc3)
`endif
    );

    typedef struct {
        bit    sel;
        bit    ez;
        int    ecnt;
        string nm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input bit sel, input bit r, input bit wv,
                        input bit ez, input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        if (sel) begin reset3 = r; w3 = wv; end
        else     begin reset2 = r; w2 = wv; end
        e.sel = sel; e.ez = ez; e.ecnt = ec; e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        bit   zv;
        int   cv;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                zv = e.sel ? z3 : z2;
                checks++;
                if (zv !== e.ez) begin
                    errors++;
                    $display("FAIL %s z: got %0b expected %0b", e.nm, zv, e.ez);
                end
`ifdef SECUENCIA_STATE_OUT_EN
                cv = e.sel ? int'(rc3) : int'(rc2);
                checks++;
                if (cv != e.ecnt) begin
                    errors++;
                    $display("FAIL %s run_cnt: got %0d expected %0d", e.nm, cv, e.ecnt);
                end
`else
                cv = e.ecnt;
`endif
            end
        end
    end

    initial begin
        #1;
        checks++;
        if (z2 !== 1'b0 || z3 !== 1'b0) begin
            errors++;
            $display("FAIL powerup z: got %0b/%0b expected 0/0", z2, z3);
        end

        // RUN_LEN=2: reset with w toggling
        step(0, 0, 1, 0, 0, "rst_a");
        step(0, 0, 0, 0, 0, "rst_b");
        // run of ones, then a zero
        step(0, 1, 1, 0, 1, "ones1");
        step(0, 1, 1, 1, 2, "ones2");
        step(0, 1, 1, 1, 2, "ones3");
        step(0, 1, 1, 1, 2, "ones4");
        step(0, 1, 0, 0, 1, "ones_brk");
        // run of zeros, then ones restarting at 1
        step(0, 0, 0, 0, 0, "rst_c");
        step(0, 1, 0, 0, 1, "zeros1");
        step(0, 1, 0, 1, 2, "zeros2");
        step(0, 1, 0, 1, 2, "zeros3");
        step(0, 1, 1, 0, 1, "chg1");
        step(0, 1, 1, 1, 2, "chg2");
        // alternating never asserts
        step(0, 0, 0, 0, 0, "rst_d");
        step(0, 1, 0, 0, 1, "alt0");
        step(0, 1, 1, 0, 1, "alt1");
        step(0, 1, 0, 0, 1, "alt2");
        step(0, 1, 1, 0, 1, "alt3");
        step(0, 1, 0, 0, 1, "alt4");
        step(0, 1, 1, 0, 1, "alt5");
        // reset while z=1
        step(0, 1, 1, 1, 2, "mid_hi");
        step(0, 0, 1, 0, 0, "mid_rst");
        step(0, 1, 1, 0, 1, "mid_rel1");
        step(0, 1, 1, 1, 2, "mid_rel2");

        // RUN_LEN=3
        step(1, 0, 0, 0, 0, "r3_rst");
        step(1, 1, 1, 0, 1, "r3_one1");
        step(1, 1, 1, 0, 2, "r3_one2");
        step(1, 1, 1, 1, 3, "r3_one3");
        step(1, 1, 1, 1, 3, "r3_one4");
        step(1, 1, 0, 0, 1, "r3_zero1");
        step(1, 1, 0, 0, 2, "r3_zero2");
        step(1, 1, 0, 1, 3, "r3_zero3");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
